// File: rtl/gol_pkg.sv
// Shared constants and FSM state type for the Game of Life generation stepper.
package gol_pkg;
    localparam int GOL_WIDTH   = 8;
    localparam int GOL_REGBITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/gol_cell_rule.sv
// Life rule for one cell: nbhd is a 3x3 window with the cell itself at bit 4.
module gol_cell_rule (
    input  logic [8:0] nbhd,
    output logic       next
);
    logic [3:0] n;

    always_comb begin
        n = '0;
        for (int k = 0; k < 9; k++) begin
            if (k != 4) n = n + {3'b000, nbhd[k]};
        end
    end

    assign next = (n == 4'd3) || (nbhd[4] && (n == 4'd2));
endmodule

// File: rtl/gol_next_gen.sv
// Reads the whole grid into a local buffer, then writes back the next generation
// row by row, computing every row from the untouched buffer.
module gol_next_gen
    import gol_pkg::*;
#(
    parameter int WIDTH   = GOL_WIDTH,
    parameter int REGBITS = GOL_REGBITS,
    parameter int WRAP    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   rd,
    output logic [REGBITS-1:0] ra,
    output logic [WIDTH-1:0]   wd,
    output logic               regwrite,
    output logic               busy,
    output logic               done,
    output logic [15:0]        gen_count
);
    localparam int ROWS = 2 ** REGBITS;

    state_t                       state, state_n;
    logic [REGBITS-1:0]           cnt;
    logic [ROWS-1:0][WIDTH-1:0]   grid;
    logic [15:0]                  gens;
    logic [REGBITS-1:0]           up_idx, dn_idx;
    logic [WIDTH-1:0]             up_row, mid_row, dn_row, next_row;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            gens  <= '0;
        end else begin
            state <= state_n;
            case (state)
                LOAD, WRITE: cnt <= cnt + 1'b1;
                default:     cnt <= '0;
            endcase
            if (state == DONE) gens <= gens + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) grid[cnt] <= rd;
    end

    always_comb begin
        state_n  = state;
        ra       = '0;
        wd       = '0;
        regwrite = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE:  if (start) state_n = LOAD;
            LOAD: begin
                ra = cnt;
                if (cnt == '1) state_n = WRITE;
            end
            WRITE: begin
                ra = cnt;
                // Reset suppresses the write in its own cycle so an aborted pass stops cleanly.
                regwrite = !reset;
                wd       = reset ? '0 : next_row;
                if (cnt == '1) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign gen_count = gens;

    // Row neighbours: index arithmetic wraps naturally; without WRAP the edges read as dead.
    assign up_idx  = cnt - 1'b1;
    assign dn_idx  = cnt + 1'b1;
    assign mid_row = grid[cnt];
    assign up_row  = (cnt == '0 && WRAP == 0) ? '0 : grid[up_idx];
    assign dn_row  = (cnt == '1 && WRAP == 0) ? '0 : grid[dn_idx];

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        localparam int L  = (i == 0) ? WIDTH - 1 : i - 1;
        localparam int R  = (i == WIDTH - 1) ? 0 : i + 1;
        localparam bit LV = (i != 0) || (WRAP != 0);
        localparam bit RV = (i != WIDTH - 1) || (WRAP != 0);
        logic [8:0] nb;

        assign nb = {dn_row[R] & RV,  dn_row[i],  dn_row[L] & LV,
                     mid_row[R] & RV, mid_row[i], mid_row[L] & LV,
                     up_row[R] & RV,  up_row[i],  up_row[L] & LV};

        gol_cell_rule u_rule (
            .nbhd (nb),
            .next (next_row[i])
        );
    end
endmodule

// File: tb/tb_gol_next_gen.sv
// Scoreboarded bench: two steppers (bounded and toroidal) each with a modelled row store.
module tb_gol_next_gen;
    typedef logic [7:0][7:0] grid_t;
    typedef struct {
        grid_t       g;
        logic [15:0] gen;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [1:0]       start;
    logic [1:0][7:0]  rd, wd;
    logic [1:0][2:0]  ra;
    logic [1:0]       regwrite, busy, done;
    logic [1:0][15:0] gen_count;

    grid_t       mem [2];
    grid_t       ld_grid;
    logic [1:0]  ld;
    grid_t       model [2];
    logic [15:0] expg [2];
    exp_t        q0[$], q1[$];
    logic [1:0]  pend_v;
    logic [15:0] pend_gen [2];
    int          checks, failures;

    gol_next_gen #(.WIDTH(8), .REGBITS(3), .WRAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .rd(rd[0]), .ra(ra[0]), .wd(wd[0]),
        .regwrite(regwrite[0]), .busy(busy[0]), .done(done[0]), .gen_count(gen_count[0]));

    gol_next_gen #(.WIDTH(8), .REGBITS(3), .WRAP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .rd(rd[1]), .ra(ra[1]), .wd(wd[1]),
        .regwrite(regwrite[1]), .busy(busy[1]), .done(done[1]), .gen_count(gen_count[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row store model: bulk load port plus the DUT write port.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (ld[s]) mem[s] <= ld_grid;
            else if (regwrite[s]) mem[s][ra[s]] <= wd[s];
        end
    end

    always_comb begin
        rd = '0;
        for (int s = 0; s < 2; s++) rd[s] = mem[s][ra[s]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic grid_t ref_step(input grid_t g, input bit wrap);
        grid_t nx;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                            n += int'(g[rr][cc]);
                        end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                            n += int'(g[rr][cc]);
                        end
                    end
                end
                nx[r][c] = (n == 3) || (g[r][c] && n == 2);
            end
        end
        return nx;
    endfunction

    function automatic grid_t rand_grid();
        grid_t g;
        for (int r = 0; r < 8; r++) g[r] = 8'($urandom);
        return g;
    endfunction

    // Monitor: pops one expected grid per done pulse, then checks the counter a cycle later.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!regwrite[s]) chk("wd_idle", 64'(wd[s]), 64'd0);
            if (regwrite[s])  chk("rw_busy", 64'(busy[s]), 64'd1);
            if (pend_v[s]) begin
                chk("gen_count", 64'(gen_count[s]), 64'(pend_gen[s]));
                pend_v[s] = 1'b0;
            end
            if (done[s]) begin
                exp_t e;
                bit   have;
                have = (s == 0) ? (q0.size() != 0) : (q1.size() != 0);
                if (!have) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done dut=%0d", s);
                end else begin
                    if (s == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    for (int r = 0; r < 8; r++) chk("grid_row", 64'(mem[s][r]), 64'(e.g[r]));
                    pend_v[s]   = 1'b1;
                    pend_gen[s] = e.gen;
                end
            end
        end
    end

    task automatic push_exp(input int s);
        exp_t e;
        e.g      = ref_step(model[s], s == 1);
        e.gen    = expg[s] + 16'd1;
        expg[s]  = e.gen;
        model[s] = e.g;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic load(input logic [1:0] m, input grid_t g);
        @(negedge clk);
        ld_grid = g;
        ld      = m;
        for (int s = 0; s < 2; s++) if (m[s]) model[s] = g;
        @(negedge clk);
        ld = '0;
    endtask

    task automatic run_gen(input logic [1:0] m);
        logic [1:0] seen;
        seen = '0;
        for (int s = 0; s < 2; s++) if (m[s]) push_exp(s);
        @(negedge clk);
        start = m;
        @(negedge clk);
        start = '0;
        for (int c = 0; c < 60 && seen != m; c++) begin
            @(negedge clk);
            seen |= done & m;
        end
        chk("run_gen_timeout", 64'(seen), 64'(m));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expg[0] = '0;
        expg[1] = '0;
    endtask

    // Cycle-exact timing of one pass on the bounded stepper, with stray starts while busy.
    task automatic timing_run();
        push_exp(0);
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk("t_regwrite", 64'(regwrite[0]), 64'(k >= 9 && k <= 16));
            chk("t_done", 64'(done[0]), 64'(k == 17));
            chk("t_busy", 64'(busy[0]), 64'(k <= 17));
            chk("t_ra", 64'(ra[0]), (k <= 16) ? 64'((k - 1) % 8) : 64'd0);
            start[0] = (k == 3 || k == 10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        grid_t g, nx, b2, z;
        int    seen, prev;

        checks = 0; failures = 0;
        reset = 1'b1; start = '0; ld = '0; ld_grid = '0; pend_v = '0;
        expg[0] = '0; expg[1] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", 64'(busy[s]), 64'd0);
            chk("rst_done", 64'(done[s]), 64'd0);
            chk("rst_regwrite", 64'(regwrite[s]), 64'd0);
            chk("rst_ra", 64'(ra[s]), 64'd0);
            chk("rst_gen", 64'(gen_count[s]), 64'd0);
        end

        // Blinker oscillates with period 2.
        g = '0;
        g[1] = 8'b00001000; g[2] = 8'b00001000; g[3] = 8'b00001000;
        b2 = '0;
        b2[2] = 8'b00011100;
        load(2'b01, g);
        timing_run();
        chk("blinker_step1", 64'(mem[0]), 64'(b2));
        run_gen(2'b01);
        @(negedge clk);
        chk("blinker_step2", 64'(mem[0]), 64'(g));

        // Block still life from a fresh reset.
        do_reset();
        g = '0;
        g[3] = 8'b00011000; g[4] = 8'b00011000;
        load(2'b01, g);
        run_gen(2'b01);
        @(negedge clk);
        chk("block_grid", 64'(mem[0]), 64'(g));
        chk("block_gen", 64'(gen_count[0]), 64'd1);

        // Block split across the top and bottom edges.
        g = '0;
        g[0] = 8'b11000000; g[7] = 8'b11000000;
        z = '0;
        load(2'b11, g);
        run_gen(2'b11);
        @(negedge clk);
        chk("edge_wrap", 64'(mem[1]), 64'(g));
        chk("edge_nowrap", 64'(mem[0]), 64'(z));

        for (int i = 0; i < 4; i++) begin
            load(2'b01, rand_grid());
            load(2'b10, rand_grid());
            run_gen(2'b11);
        end

        // start held high chains generations with one idle cycle between them.
        load(2'b10, rand_grid());
        for (int i = 0; i < 3; i++) push_exp(1);
        @(negedge clk);
        start[1] = 1'b1;
        seen = 0; prev = 0;
        for (int c = 1; c <= 100 && seen < 3; c++) begin
            @(negedge clk);
            if (done[1]) begin
                seen++;
                if (seen > 1) chk("b2b_gap", 64'(c - prev), 64'd18);
                prev = c;
                if (seen == 3) start[1] = 1'b0;
            end
        end
        start[1] = 1'b0;
        chk("b2b_count", 64'(seen), 64'd3);

        // Reset in the middle of the write pass.
        g  = rand_grid();
        g[3] = ~g[3];
        load(2'b01, g);
        nx = ref_step(g, 1'b0);
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        chk("mid_gen_before", 64'(gen_count[0]), 64'(expg[0]));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_regwrite", 64'(regwrite[0]), 64'd0);
        chk("mid_busy", 64'(busy[0]), 64'd0);
        chk("mid_gen", 64'(gen_count[0]), 64'd0);
        chk("mid_done", 64'(done[0]), 64'd0);
        reset = 1'b0;
        expg[0] = '0; expg[1] = '0;
        @(negedge clk);
        for (int r = 0; r < 8; r++)
            chk("mid_row", 64'(mem[0][r]), (r < 3) ? 64'(nx[r]) : 64'(g[r]));

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
